// File: rtl/serial_adder_pkg.sv
// serial_adder shared types: FSM state enum, WIDTH bounds, counter width.
// No ports; imported by the datapath and the interface users.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bit counter width; never below one bit.
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder operand/result bundle with two valid/ready channels.
// master: producer/consumer side; slave: the adder itself.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, c_in, sub,
    output out_ready,
    input  in_ready, out_valid,
    input  sum, c_out, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, sub,
    input  out_ready,
    output in_ready, out_valid,
    output sum, c_out, ovf, busy
  );

endinterface

// File: rtl/serial_adder_fa_slice.sv
// One-bit combinational full adder; carry storage lives in the parent.
// Ports: a, b, cin -> s, cout.
module serial_adder_fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock through a single slice.
// Ports: clk, reset_n (async, active low), io (slave side of serial_adder_if).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           reset_n,
  serial_adder_if.slave io
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic fa_s;
  logic fa_co;

  serial_adder_fa_slice u_fa_slice (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (cy_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    co_d    = co_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          // Subtract is A + ~B + 1: invert B here, seed carry with 1.
          a_sh_d  = io.a;
          b_sh_d  = io.sub ? ~io.b : io.b;
          cy_d    = io.sub ? 1'b1 : io.c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {fa_s, res_q[WIDTH-1:1]};
        cy_d   = fa_co;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // cy_q is the carry into the MSB on this last bit.
          co_d    = fa_co;
          ov_d    = cy_q ^ fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    io.in_ready  = (state_q == IDLE);
    io.out_valid = (state_q == DONE);
    io.busy      = (state_q != IDLE);
    io.sum       = res_q;
    io.c_out     = co_q;
    io.ovf       = ov_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases at WIDTH=8 plus random
// scoreboarded traffic at WIDTH=8, 2 and 32 against an arithmetic model.
module tb_serial_adder;

  localparam int N_RND = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic longint sext(input longint unsigned x, input int w);
    if (((x >> (w - 1)) & 64'd1) != 0)
      return longint'(x) - (longint'(1) <<< w);
    return longint'(x);
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input longint unsigned a,
                                input longint unsigned b, input bit cin,
                                input bit sub,
                                output longint unsigned s,
                                output bit co, output bit ov);
    longint unsigned m, t;
    longint sa, sb, st, lim;
    m   = (64'd1 << w) - 64'd1;
    sa  = sext(a, w);
    sb  = sext(b, w);
    lim = longint'(1) <<< (w - 1);
    if (sub) begin
      t  = a - b;
      co = (a >= b);
      st = sa - sb;
    end else begin
      t  = a + b + longint'(cin);
      co = ((t >> w) & 64'd1) != 0;
      st = sa + sb + longint'(cin);
    end
    s  = t & m;
    ov = (st >= lim) || (st < -lim);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed instance, WIDTH=8 ----------------
  logic dn;
  serial_adder_if #(.WIDTH(8)) d_if ();
  serial_adder #(.WIDTH(8)) u_dut (
    .clk     (clk),
    .reset_n (dn),
    .io      (d_if)
  );

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, d_if.in_ready, 1);
    chk({tag, "_out_valid"}, d_if.out_valid, 0);
    chk({tag, "_busy"}, d_if.busy, 0);
    chk({tag, "_sum"}, d_if.sum, 0);
    chk({tag, "_c_out"}, d_if.c_out, 0);
    chk({tag, "_ovf"}, d_if.ovf, 0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input bit cin, input bit sub,
                        input bit chk_lat);
    int n;
    longint unsigned es;
    bit eco, eov;
    model(8, a, b, cin, sub, es, eco, eov);
    n = 0;
    while (!d_if.in_ready && n < 100) begin tick(); n++; end
    chk({tag, "_in_ready"}, d_if.in_ready, 1);
    d_if.a = a; d_if.b = b; d_if.c_in = cin; d_if.sub = sub;
    d_if.in_valid = 1'b1;
    tick();
    d_if.in_valid = 1'b0;
    d_if.a = 8'($urandom); d_if.b = 8'($urandom);
    d_if.c_in = 1'($urandom); d_if.sub = 1'($urandom);
    n = 1;
    while (!d_if.out_valid && n < 100) begin tick(); n++; end
    if (chk_lat) chk({tag, "_latency"}, n, 9);
    chk({tag, "_sum"}, d_if.sum, es[7:0]);
    chk({tag, "_c_out"}, d_if.c_out, eco);
    chk({tag, "_ovf"}, d_if.ovf, eov);
    d_if.out_ready = 1'b1;
    tick();
    d_if.out_ready = 1'b0;
    chk({tag, "_ready_after"}, {d_if.in_ready, d_if.out_valid}, 2'b10);
  endtask

  task automatic backpressure();
    int n;
    longint unsigned es;
    bit eco, eov;
    model(8, 64'h3C, 64'h0F, 1'b0, 1'b0, es, eco, eov);
    d_if.a = 8'h3C; d_if.b = 8'h0F; d_if.c_in = 0; d_if.sub = 0;
    d_if.in_valid = 1'b1;
    tick();
    d_if.in_valid = 1'b0;
    n = 0;
    while (!d_if.out_valid && n < 100) begin tick(); n++; end
    chk("bp_out_valid", d_if.out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      d_if.in_valid = 1'b1;
      d_if.a = 8'($urandom); d_if.b = 8'($urandom);
      d_if.sub = 1'($urandom);
      tick();
      chk("bp_hold",
          {d_if.out_valid, d_if.in_ready, d_if.busy,
           d_if.c_out, d_if.ovf, d_if.sum},
          {3'b101, eco, eov, es[7:0]});
    end
    d_if.in_valid = 1'b0;
    d_if.out_ready = 1'b1;
    tick();
    d_if.out_ready = 1'b0;
    chk("bp_release", {d_if.in_ready, d_if.out_valid}, 2'b10);
  endtask

  task automatic back_to_back();
    int idx[$];
    int n;
    d_if.a = 8'h80; d_if.b = 8'h01; d_if.c_in = 0; d_if.sub = 1;
    d_if.in_valid = 1'b1;
    d_if.out_ready = 1'b1;
    for (int c = 0; c < 40 && idx.size() < 2; c++) begin
      if (d_if.in_ready) idx.push_back(c);
      tick();
    end
    d_if.in_valid = 1'b0;
    chk("b2b_accepts", idx.size(), 2);
    if (idx.size() == 2) chk("b2b_spacing", idx[1] - idx[0], 10);
    n = 0;
    while (!d_if.in_ready && n < 40) begin tick(); n++; end
    d_if.out_ready = 1'b0;
    chk("b2b_drain", d_if.in_ready, 1);
    chk("b2b_res", {d_if.c_out, d_if.ovf, d_if.sum}, {2'b11, 8'h7F});
  endtask

  task automatic reset_mid_run();
    int seen;
    d_if.a = 8'hAA; d_if.b = 8'h55; d_if.c_in = 0; d_if.sub = 0;
    d_if.in_valid = 1'b1;
    tick();
    d_if.in_valid = 1'b0;
    repeat (3) tick();
    chk("rst_busy_before", d_if.busy, 1);
    #2;
    dn = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    d_if.in_valid = 1'b1;
    tick();
    tick();
    chk_reset_vals("rst_held");
    d_if.in_valid = 1'b0;
    dn = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (d_if.out_valid) seen++;
    end
    chk("rst_no_out_valid", seen, 0);
  endtask

  // ---------------- random instances ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 2 : 32;
    logic rn;
    bit   fin = 1'b0;
    serial_adder_if #(.WIDTH(W)) rif ();
    serial_adder #(.WIDTH(W)) u_rdut (
      .clk     (clk),
      .reset_n (rn),
      .io      (rif)
    );

    initial begin
      longint unsigned es;
      bit eco, eov, done, rc, rs;
      int n;
      logic [W-1:0] ra, rb;
      rn = 1'b0;
      rif.in_valid = 1'b0; rif.out_ready = 1'b0;
      rif.a = '0; rif.b = '0; rif.c_in = 1'b0; rif.sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rn = 1'b1;
      for (int k = 0; k < N_RND; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        ra = W'($urandom); rb = W'($urandom);
        rc = 1'($urandom); rs = 1'($urandom);
        model(W, 64'(ra), 64'(rb), rc, rs, es, eco, eov);
        n = 0;
        while (!rif.in_ready && n < 100) begin
          @(posedge clk); #1; n++;
        end
        rif.a = ra; rif.b = rb; rif.c_in = rc; rif.sub = rs;
        rif.in_valid = 1'b1;
        @(posedge clk); #1;
        rif.in_valid = 1'b0;
        done = 1'b0;
        n = 0;
        while (!done && n < 400) begin
          rif.out_ready = ($urandom_range(0, 3) != 0);
          if (rif.out_valid && rif.out_ready) begin
            chk($sformatf("rnd_w%0d_sum", W), 64'(rif.sum), es);
            chk($sformatf("rnd_w%0d_c_out", W), rif.c_out, eco);
            chk($sformatf("rnd_w%0d_ovf", W), rif.ovf, eov);
            done = 1'b1;
          end
          @(posedge clk); #1;
          n++;
        end
        rif.out_ready = 1'b0;
        chk($sformatf("rnd_w%0d_complete", W), done, 1);
      end
      fin = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    dn = 1'b0;
    d_if.in_valid = 1'b0; d_if.out_ready = 1'b0;
    d_if.a = '0; d_if.b = '0; d_if.c_in = 1'b0; d_if.sub = 1'b0;
    repeat (2) tick();
    chk_reset_vals("reset");
    dn = 1'b1;
    tick();
    chk_reset_vals("post_reset");

    run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    chk("add_wrap_exact", 8'h00, d_if.sum);
    run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("add_ovf_flag", d_if.ovf, 1);
    run_op("add_cin", 8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    chk("add_cin_sum", d_if.sum, 8'h31);
    run_op("sub_neg", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    chk("sub_neg_sum", d_if.sum, 8'hFE);
    run_op("sub_cin_ign", 8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
    chk("sub_cin_ign_sum", d_if.sum, 8'hFE);
    run_op("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("sub_ovf_flags", {d_if.c_out, d_if.ovf, d_if.sum}, {2'b11, 8'h7F});

    backpressure();
    back_to_back();
    reset_mid_run();
    run_op("after_rst", 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    chk("after_rst_sum", d_if.sum, 8'h46);

    n = 0;
    while (!(g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin) && n < 80000) begin
      tick();
      n++;
    end
    chk("rnd_all_finished",
        {g_rnd[0].fin, g_rnd[1].fin, g_rnd[2].fin}, 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor: the multi-bit successor to the single-bit registered full-adder cell. It accepts two WIDTH-bit operands through a valid/ready handshake. It resolves one bit per clock through a single registered full-adder slice with a carry flip-flop, then presents sum, carry-out and signed overflow through a second valid/ready handshake. It sits between operand-producing logic and result consumers in the perceptron datapath, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- c_in  input  1  carry seed for add; ignored when sub=1.
- sub  input  1  0: A+B+c_in; 1: A−B, computed as A+~B+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- c_out  output  1  carry out of MSB; in sub mode 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a and (sub ? ~b : b) into shift registers.
  - Carry flop ← (sub ? 1 : c_in); bit counter ← 0; go to RUN.
- RUN:
  - Each cycle the slice adds LSB(a_sh), LSB(b_sh) and the carry flop.
  - The sum bit shifts into the MSB of the result register, which shifts right.
  - Carry flop takes the slice carry; counter increments.
  - When the counter reaches WIDTH−1, capture the carry into the MSB (the carry flop value that cycle) for ovf, then go to DONE.
- DONE:
  - out_valid=1; sum, c_out and ovf are stable and held.
  - On out_ready, go to IDLE.
- Inputs a, b, c_in and sub are ignored outside the accepting cycle.
- in_valid is ignored in RUN and DONE; there is no operand queueing.
- Arithmetic is modulo 2^WIDTH, and the sum is bit-exact to (a + (sub?~b:b) + seed) mod 2^WIDTH.
- c_out is bit WIDTH of that sum.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, ovf=0; counter 0; carry flop 0.
- All handshakes are ignored while reset_n=0.
- Operand accepted at edge T; RUN occupies edges T+1..T+WIDTH; out_valid rises after edge T+WIDTH.
  - Latency from acceptance to out_valid: WIDTH+1 cycles.
- Result handshake completes at the edge where out_valid&&out_ready. in_ready is 1 the following cycle.
  - Minimum initiation interval: WIDTH+2 cycles.
- out_ready held low: the block stays in DONE indefinitely with outputs unchanged.
- out_ready high before DONE has no effect.
- Counter wrap: the counter never exceeds WIDTH−1. Its width is $clog2(WIDTH).
- Reset asserted mid-RUN or mid-DONE:
  - State, counter, carry and outputs return to their reset values immediately, without waiting for a clock.
  - The in-flight result is discarded; no out_valid pulse is produced.
- Outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- The shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the WIDTH legality bounds;
  - a function giving the counter width.
- Sub-module fa_slice:
  - Combinational one-bit full adder: a, b, cin → s, cout.
  - Instantiated once; the carry register lives in the parent.
- The parent holds the FSM, shift registers, counter, carry flop and output registers.

## Test plan
All cases use WIDTH=8.
- Add with wrap: 0xFF+0x01, c_in=0, sub=0 → sum=0x00, c_out=1, ovf=0. out_valid arrives exactly 9 cycles after acceptance.
- Signed overflow: 0x7F+0x01 → sum=0x80, c_out=0, ovf=1. With c_in=1, 0x10+0x20 → 0x31, ovf=0.
- Subtract:
  - 0x05−0x07 → 0xFE, c_out=0, ovf=0.
  - 0x80−0x01 → 0x7F, c_out=1, ovf=1.
  - c_in=1 has no effect when sub=1.
- Backpressure:
  - out_ready low for 20 cycles → outputs held, in_ready=0, new in_valid ignored.
  - Release → handshake completes; in_ready=1 next cycle.
  - Back-to-back operations are spaced 10 cycles apart.
- Reset mid-operation:
  - reset_n pulsed low at RUN bit 3 → all outputs take reset values asynchronously, and no out_valid follows.
  - A next operation 0x12+0x34 → 0x46.
- Random: 1000 random a, b, c_in and sub operations with random out_ready stalls, scoreboarded against a reference model of sum, c_out and ovf; also repeated with WIDTH=2 and WIDTH=32.
